sr_ff_exerciser: RTL

Self-checking stimulus/response engine for the team's clocked J/K flip-flop with preset (PR, active-high) and clear (CLR, active-low) inputs. It sits on the driving side of that flip-flop's interface. On a START request it drives a fixed 8-step vector sequence into the flop's J/K/PR/CLR pins. It checks the flop's P (set-side) and Q (complement) outputs after every step, then reports pass/fail, an error count and the first failing step. It is used on-board and in benches as a go/no-go self-test for each flop instance.

---
 rtl/sr_ff_exerciser.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sr_ff_exerciser.sv
// Go/no-go self-test engine for a J/K flop with preset/clear.
// Ports: CLK/CLR(sync, act-low) START -> BUSY DONE PASS ERR_CNT FAIL_STEP; FF_J/K/PR/CLR drive, FF_P/Q sense.
module sr_ff_exerciser #(
  parameter int unsigned LOOPS = 1,
  parameter int unsigned ERR_W = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [2:0]       FAIL_STEP,
  output logic             FF_J,
  output logic             FF_K,
  output logic             FF_PR,
  output logic             FF_CLR,
  input  logic             FF_P,
  input  logic             FF_Q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK,
    S_DONE
  } state_t;

  // {J,K,PR,CLR} that leaves the flop untouched
  localparam logic [3:0] IDLE_DRV = 4'b0001;
  localparam logic [7:0] LAST_LOOP = 8'(LOOPS - 1);

  state_t           state_q;
  logic [2:0]       step_q;
  logic [7:0]       loop_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [2:0]       fstep_q;
  logic [3:0]       drv_q;

  logic [1:0]       exp_d;
  logic             miss_d;
  logic             last_d;
  logic [ERR_W-1:0] err_d;

  function automatic logic [3:0] vec(input logic [2:0] s);
    logic [3:0] v;
    unique case (s)
      3'd0: v = 4'b0011;
      3'd1: v = 4'b0000;
      3'd2: v = 4'b1001;
      3'd3: v = 4'b0001;
      3'd4: v = 4'b0101;
      3'd5: v = 4'b0001;
      3'd6: v = 4'b1001;
      3'd7: v = 4'b0110;
      default: v = IDLE_DRV;
    endcase
    return v;
  endfunction

  // Expected {P,Q}; Q is always the complement of P
  function automatic logic [1:0] expv(input logic [2:0] s);
    logic p;
    unique case (s)
      3'd1, 3'd4, 3'd5: p = 1'b0;
      default:          p = 1'b1;
    endcase
    return {p, ~p};
  endfunction

  always_comb begin
    exp_d  = expv(step_q);
    // identity compare so X/Z on the flop pins counts as a miss
    miss_d = !({FF_P, FF_Q} === exp_d);
    last_d = (step_q == 3'd7) && (loop_q == LAST_LOOP);
    err_d  = err_q;
    if (miss_d && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      loop_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fstep_q <= '0;
      drv_q   <= IDLE_DRV;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            state_q <= S_DRIVE;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fstep_q <= '0;
            step_q  <= '0;
            loop_q  <= '0;
            drv_q   <= vec(3'd0);
          end
        end
        S_DRIVE: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          err_q <= err_d;
          // saturating count never returns to zero,
          // so zero means no earlier miss
          if (miss_d && (err_q == '0)) begin
            fstep_q <= step_q;
          end
          if (last_d) begin
            drv_q   <= IDLE_DRV;
            pass_q  <= (err_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            step_q <= step_q + 3'd1;
            if (step_q == 3'd7) begin
              loop_q <= loop_q + 8'd1;
            end
            drv_q   <= vec(step_q + 3'd1);
            state_q <= S_DRIVE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign ERR_CNT   = err_q;
  assign FAIL_STEP = fstep_q;
  assign FF_J      = drv_q[3];
  assign FF_K      = drv_q[2];
  assign FF_PR     = drv_q[1];
  assign FF_CLR    = drv_q[0];

endmodule
